// File: rtl/idct_pkg.sv
// Shared constants, state encoding and {hi,lo} address packing for the 8x8 IDCT sequencer.
package idct_pkg;
  localparam int IDCT_N = 8;
  localparam int IDX_W  = 3;
  localparam int ADDR_W = 6;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ROW_ISSUE,
    ST_ROW_WAIT,
    ST_ROW_WB,
    ST_COL_ISSUE,
    ST_COL_WAIT,
    ST_COL_OUT,
    ST_DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] pack_addr(input logic [IDX_W-1:0] hi,
                                                   input logic [IDX_W-1:0] lo);
    return {hi, lo};
  endfunction
endpackage

// File: rtl/idct_loop_counter.sv
// Nested term/output/block counters (k, j, i), each 3 bits and wrapping 7->0.
// step_ji advances j and carries into i when j wraps; pass_wrap flags the last dot product.
module idct_loop_counter
  import idct_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             step_k,
  input  logic             step_ji,
  output logic [IDX_W-1:0] k_cnt,
  output logic [IDX_W-1:0] j_cnt,
  output logic [IDX_W-1:0] i_cnt,
  output logic             k_wrap,
  output logic             pass_wrap
);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(IDCT_N - 1);

  logic [IDX_W-1:0] k_q, k_d;
  logic [IDX_W-1:0] j_q, j_d;
  logic [IDX_W-1:0] i_q, i_d;

  always_comb begin
    k_d = k_q;
    j_d = j_q;
    i_d = i_q;
    if (step_k) begin
      k_d = k_q + 1'b1;
    end
    if (step_ji) begin
      j_d = j_q + 1'b1;
      if (j_q == LAST_IDX) begin
        i_d = i_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k_q <= '0;
      j_q <= '0;
      i_q <= '0;
    end else begin
      k_q <= k_d;
      j_q <= j_d;
      i_q <= i_d;
    end
  end

  assign k_cnt     = k_q;
  assign j_cnt     = j_q;
  assign i_cnt     = i_q;
  assign k_wrap    = (k_q == LAST_IDX);
  assign pass_wrap = (j_q == LAST_IDX) && (i_q == LAST_IDX);
endmodule

// File: rtl/idct_sequencer.sv
// Control sequencer for the shared IDCT MAC: load 64 coefs, row pass into transpose buffer, column pass out.
// Pixels leave on a valid/ready handshake that stalls the column pass; IDCT_CYCLE_CNT_EN adds cycle_count.
module idct_sequencer
  import idct_pkg::*;
#(
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              cbuf_we,
  output logic [ADDR_W-1:0] cbuf_waddr,
  output logic [ADDR_W-1:0] cbuf_raddr,
  output logic              tbuf_we,
  output logic [ADDR_W-1:0] tbuf_waddr,
  output logic [ADDR_W-1:0] tbuf_raddr,
  output logic              src_sel,
  output logic [IDX_W-1:0]  wt_row,
  output logic [IDX_W-1:0]  wt_col,
  output logic              mac_en,
  output logic              mac_clr,
  output logic              mac_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr
`ifdef IDCT_CYCLE_CNT_EN
  ,
  output logic [15:0]       cycle_count
`endif
);
  localparam int                WAIT_CYC  = RD_LAT + MAC_LAT;
  localparam logic [2:0]        WAIT_LAST = 3'(WAIT_CYC - 1);
  localparam logic [ADDR_W-1:0] LOAD_LAST = ADDR_W'(IDCT_N * IDCT_N - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [2:0]        wait_q, wait_d;
  logic [2:0]        strb_q [RD_LAT];

  logic             step_k, step_ji, k_wrap, pass_wrap, wait_done;
  logic [IDX_W-1:0] k_cnt, j_cnt, i_cnt;
  logic [2:0]       iss_strb;

  idct_loop_counter u_cnt (
    .clk      (clk),
    .rst      (rst),
    .step_k   (step_k),
    .step_ji  (step_ji),
    .k_cnt    (k_cnt),
    .j_cnt    (j_cnt),
    .i_cnt    (i_cnt),
    .k_wrap   (k_wrap),
    .pass_wrap(pass_wrap)
  );

  assign wait_done = (wait_q == WAIT_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (start) state_d = ST_LOAD;
      ST_LOAD:      if (in_valid && (waddr_q == LOAD_LAST)) state_d = ST_ROW_ISSUE;
      ST_ROW_ISSUE: if (k_wrap) state_d = ST_ROW_WAIT;
      ST_ROW_WAIT:  if (wait_done) state_d = ST_ROW_WB;
      ST_ROW_WB:    state_d = pass_wrap ? ST_COL_ISSUE : ST_ROW_ISSUE;
      ST_COL_ISSUE: if (k_wrap) state_d = ST_COL_WAIT;
      ST_COL_WAIT:  if (wait_done) state_d = ST_COL_OUT;
      ST_COL_OUT:   if (out_ready) state_d = pass_wrap ? ST_DONE : ST_COL_ISSUE;
      ST_DONE:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = 1'b0;
    in_ready   = 1'b0;
    cbuf_raddr = '0;
    tbuf_we    = 1'b0;
    tbuf_waddr = '0;
    tbuf_raddr = '0;
    src_sel    = 1'b0;
    wt_row     = '0;
    wt_col     = '0;
    out_valid  = 1'b0;
    out_addr   = '0;
    step_k     = 1'b0;
    step_ji    = 1'b0;
    iss_strb   = 3'b000;
    case (state_q)
      ST_LOAD: in_ready = 1'b1;
      ST_ROW_ISSUE: begin
        cbuf_raddr = pack_addr(i_cnt, k_cnt);
        wt_row     = j_cnt;
        wt_col     = k_cnt;
        step_k     = 1'b1;
        iss_strb   = {1'b1, (k_cnt == '0), k_wrap};
      end
      ST_ROW_WB: begin
        // Stored at {j,i} so the column pass can read it back as {i,k}.
        tbuf_we    = 1'b1;
        tbuf_waddr = pack_addr(j_cnt, i_cnt);
        step_ji    = 1'b1;
      end
      ST_COL_ISSUE: begin
        src_sel    = 1'b1;
        tbuf_raddr = pack_addr(i_cnt, k_cnt);
        wt_row     = j_cnt;
        wt_col     = k_cnt;
        step_k     = 1'b1;
        iss_strb   = {1'b1, (k_cnt == '0), k_wrap};
      end
      ST_COL_WAIT: src_sel = 1'b1;
      ST_COL_OUT: begin
        src_sel   = 1'b1;
        out_valid = 1'b1;
        out_addr  = pack_addr(j_cnt, i_cnt);
        step_ji   = out_ready;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign cbuf_we    = in_ready & in_valid;
  assign cbuf_waddr = waddr_q;

  always_comb begin
    waddr_d = cbuf_we ? waddr_q + 1'b1 : waddr_q;
    wait_d  = '0;
    if (((state_q == ST_ROW_WAIT) || (state_q == ST_COL_WAIT)) && !wait_done) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      waddr_q <= '0;
      wait_q  <= '0;
    end else begin
      waddr_q <= waddr_d;
      wait_q  <= wait_d;
    end
  end

  // MAC strobes line up with the RAM data, which arrives RD_LAT cycles after the address.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) strb_q[s] <= '0;
    end else begin
      strb_q[0] <= iss_strb;
      for (int s = 1; s < RD_LAT; s++) strb_q[s] <= strb_q[s-1];
    end
  end

  assign {mac_en, mac_clr, mac_last} = strb_q[RD_LAT-1];

`ifdef IDCT_CYCLE_CNT_EN
  logic [15:0] cyc_q, cyc_d;

  always_comb begin
    cyc_d = cyc_q;
    if ((state_q == ST_IDLE) && start) begin
      cyc_d = '0;
    end else if ((state_q != ST_IDLE) && (state_q != ST_DONE) && (cyc_q != 16'hFFFF)) begin
      cyc_d = cyc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cyc_q <= '0;
    end else begin
      cyc_q <= cyc_d;
    end
  end

  assign cycle_count = cyc_q;
`endif
endmodule

// File: tb/tb_idct_sequencer.sv
// Bench for idct_sequencer: block-level timeline model (dot index + cycle offset) compared every cycle,
// plus literal latency/address expectations for the directed scenarios.
module tb_idct_sequencer;
  localparam int RD      = 1;
  localparam int ML      = 1;
  localparam int DOT_LEN = 8 + RD + ML + 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic       busy, done, in_ready, cbuf_we, tbuf_we, src_sel;
  logic       mac_en, mac_clr, mac_last, out_valid;
  logic [5:0] cbuf_waddr, cbuf_raddr, tbuf_waddr, tbuf_raddr, out_addr;
  logic [2:0] wt_row, wt_col;
`ifdef IDCT_CYCLE_CNT_EN
  logic [15:0] cycle_count;
`endif

  idct_sequencer #(.RD_LAT(RD), .MAC_LAT(ML)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .cbuf_we(cbuf_we),
    .cbuf_waddr(cbuf_waddr), .cbuf_raddr(cbuf_raddr), .tbuf_we(tbuf_we),
    .tbuf_waddr(tbuf_waddr), .tbuf_raddr(tbuf_raddr), .src_sel(src_sel),
    .wt_row(wt_row), .wt_col(wt_col), .mac_en(mac_en), .mac_clr(mac_clr),
    .mac_last(mac_last), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr)
`ifdef IDCT_CYCLE_CNT_EN
    , .cycle_count(cycle_count)
`endif
  );

  int total = 0, bad = 0;
  int wr_seq = 0, tb_cnt = 0;
  logic [5:0] tb_first = '0, tb_ninth = '0;

  // Model: phase 0 idle, 1 load, 2 compute, 3 done. In compute, each dot product is
  // DOT_LEN cycles: 8 issue, RD+ML wait, 1 write-back/output (the output cycle repeats while not accepted).
  int m_phase = 0, m_cnt = 0, m_pass = 0, m_dot = 0, m_t = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_pass = 0; m_dot = 0; m_t = 0;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_cnt = 0; end
        1: if (in_valid) begin
             m_cnt++;
             if (m_cnt == 64) begin m_phase = 2; m_cnt = 0; m_pass = 0; m_dot = 0; m_t = 0; end
           end
        2: if (m_t < DOT_LEN - 1) m_t++;
           else if (m_pass == 0 || out_ready) begin
             m_t = 0;
             m_dot++;
             if (m_dot == 64) begin
               m_dot = 0;
               if (m_pass == 0) m_pass = 1; else m_phase = 3;
             end
           end
        default: begin m_phase = 0; m_pass = 0; end
      endcase
    end
  end

  function automatic logic [45:0] model_out(input logic iv);
    logic [5:0] cw, cr, tw, tr, oa;
    logic [2:0] wr, wc;
    logic bz, dn, ir, cwe, twe, ss, me, mc, ml, ov;
    int i, j;
    cw = '0; cr = '0; tw = '0; tr = '0; oa = '0; wr = '0; wc = '0;
    twe = 1'b0; ss = 1'b0; me = 1'b0; mc = 1'b0; ml = 1'b0; ov = 1'b0;
    bz  = (m_phase != 0);
    dn  = (m_phase == 3);
    ir  = (m_phase == 1);
    cwe = ir & iv;
    if (m_phase == 1) cw = 6'(m_cnt);
    if (m_phase == 2) begin
      i  = m_dot / 8;
      j  = m_dot % 8;
      ss = (m_pass == 1);
      if (m_t < 8) begin
        if (m_pass == 0) cr = 6'(i * 8 + m_t); else tr = 6'(i * 8 + m_t);
        wr = 3'(j);
        wc = 3'(m_t);
      end
      me = (m_t >= RD) && (m_t <= 7 + RD);
      mc = (m_t == RD);
      ml = (m_t == 7 + RD);
      if (m_t == DOT_LEN - 1) begin
        if (m_pass == 0) begin twe = 1'b1; tw = 6'(j * 8 + i); end
        else begin ov = 1'b1; oa = 6'(j * 8 + i); end
      end
    end
    return {bz, dn, ir, cwe, cw, cr, twe, tw, tr, ss, wr, wc, me, mc, ml, ov, oa};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_all();
    logic [45:0] act, exp;
    exp = model_out(in_valid);
    act = {busy, done, in_ready, cbuf_we, cbuf_waddr, cbuf_raddr, tbuf_we, tbuf_waddr,
           tbuf_raddr, src_sel, wt_row, wt_col, mac_en, mac_clr, mac_last, out_valid, out_addr};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL outputs @%0t: dut=%h model=%h", $time, act, exp);
    end
    if (cbuf_we === 1'b1) begin
      chk("cbuf_waddr_seq", 64'(cbuf_waddr), 64'(wr_seq[5:0]));
      wr_seq++;
    end
    if (tbuf_we === 1'b1) begin
      if (tb_cnt == 0) tb_first = tbuf_waddr;
      if (tb_cnt == 8) tb_ninth = tbuf_waddr;
      tb_cnt++;
    end
  endtask

  task automatic to_neg();
    @(negedge clk);
    compare_all();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #2;
  endtask

  // iv_mode: 0 high, 1 toggle 1,0, 2 random. or_mode: 0 high, 1 stall 5 on 3rd pixel, 2 random, 3 low for 65600 cycles.
  // lat = edges from the start-sampling edge to the edge at which done is sampled high.
  task automatic run_block(input int iv_mode, input int or_mode, input int extra_start,
                           input int budget, output int lat);
    int n, acc, stall;
    wr_seq = 0; tb_cnt = 0;
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    to_neg();
    to_pos();
    start = 1'b0;
    n = 0; acc = 0; stall = 0; lat = -1;
    while (n < budget && lat < 0) begin
      case (iv_mode)
        0: in_valid = 1'b1;
        1: in_valid = (n % 2 == 0);
        default: in_valid = ($urandom_range(0, 3) != 0);
      endcase
      case (or_mode)
        0: out_ready = 1'b1;
        1: out_ready = !(acc == 2 && stall < 5);
        2: out_ready = 1'($urandom_range(0, 1));
        default: out_ready = (n >= 65600);
      endcase
      start = (n == extra_start);
      to_neg();
      if (out_valid && out_ready) acc++;
      if (or_mode == 1 && out_valid && !out_ready) begin
        stall++;
        chk("stall_out_addr", 64'(out_addr), 64'd16);
      end
      if (done) lat = n + 1;
      to_pos();
      n++;
    end
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    if (lat < 0) begin
      bad++; total++;
      $display("FAIL done_timeout: no done within %0d cycles", budget);
    end
    to_neg();
    chk("busy_after_done", 64'(busy), 64'd0);
    if (lat >= 0) chk("block_writes", 64'(wr_seq), 64'd64);
    if (or_mode == 1) chk("stall_cycles", 64'(stall), 64'd5);
    to_pos();
  endtask

  initial begin
    int lat, n;
    rst = 1'b1;
    to_pos();
    to_pos();
    to_neg();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    to_pos();
    rst = 1'b0;
    to_neg();
    to_pos();

    // Nominal block
    run_block(0, 0, -1, 3000, lat);
    chk("lat_nominal", 64'(lat), 64'd1473);
    chk("tbuf_first_addr", 64'(tb_first), 64'd0);
    chk("tbuf_ninth_addr", 64'(tb_ninth), 64'd1);
    chk("tbuf_writes", 64'(tb_cnt), 64'd64);
`ifdef IDCT_CYCLE_CNT_EN
    chk("cycle_count_nominal", 64'(cycle_count), 64'd1472);
`endif

    // Consumer stalls five cycles on the third pixel
    run_block(0, 1, -1, 3000, lat);
    chk("lat_stall", 64'(lat), 64'd1478);

    // Reset during the row pass aborts the block
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    to_neg();
    to_pos();
    start = 1'b0;
    n = 0;
    to_neg();
    while (n < 200 && !(busy && !in_ready)) begin
      to_pos();
      to_neg();
      n++;
    end
    chk("reach_row_issue", 64'(n < 200), 64'd1);
    to_pos();
    rst = 1'b1;
    to_neg();
    to_pos();
    rst = 1'b0; in_valid = 1'b0;
    to_neg();
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_mac_en", 64'(mac_en), 64'd0);
    chk("abort_cbuf_raddr", 64'(cbuf_raddr), 64'd0);
    to_pos();
    run_block(0, 0, -1, 3000, lat);
    chk("lat_after_abort", 64'(lat), 64'd1473);

    // Extra start while busy, in_valid alternating 1,0: 63 idle load cycles added
    run_block(1, 0, 10, 3000, lat);
    chk("lat_toggle", 64'(lat), 64'd1536);

    for (int b = 0; b < 3; b++) begin
      run_block(2, 2, int'($urandom_range(0, 400)), 6000, lat);
    end

`ifdef IDCT_CYCLE_CNT_EN
    run_block(0, 3, -1, 70000, lat);
    chk("cycle_count_sat", 64'(cycle_count), 64'hFFFF);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
